// File: rtl/rob_pkg.sv
// Shared rename/ROB definitions: tag geometry, tag type and instruction-type encodings.
package rob_pkg;

  localparam int unsigned TAG_W     = 5;
  localparam int unsigned ROB_DEPTH = 32;
  localparam int unsigned CNT_W     = TAG_W + 1;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    INST_RD_VALID = 2'b00,
    INST_BRANCH   = 2'b01,
    INST_STORE    = 2'b10
  } inst_type_e;

  // Retire-side tag return as carried on the ROB retire bus.
  typedef struct packed {
    logic valid;
    tag_t tag;
  } tag_ret_t;

endpackage

// File: rtl/tag_fifo.sv
// Free-list allocator for rename/ROB tags: show-ahead alloc, retire-side free, flush reinit.
// Optional duplicate-free detection is enabled with `define TAG_FIFO_DUPCHK_EN.
module tag_fifo
  import rob_pkg::*;
#(
  parameter int unsigned TAG_W = rob_pkg::TAG_W,
  parameter int unsigned DEPTH = rob_pkg::ROB_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_valid,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [TAG_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow_err,
  output logic             dup_err
);

  localparam int unsigned CW = TAG_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             empty_c, full_c;
  logic             alloc_acc_c, free_acc_c;
  logic             free_ok_c;

  assign empty_c     = (count_q == '0);
  assign full_c      = (count_q == CW'(DEPTH));
  assign alloc_acc_c = alloc_req && !empty_c && !flush;

`ifdef TAG_FIFO_DUPCHK_EN
  logic [DEPTH-1:0] in_use_q, in_use_d;
  logic             dup_q, dup_d;

  // Only tags currently out on the pipeline may come back.
  assign free_ok_c = in_use_q[free_tag];

  always_comb begin
    in_use_d = in_use_q;
    dup_d    = dup_q;
    if (flush) begin
      in_use_d = '0;
    end else begin
      if (free_valid && !full_c && !free_ok_c) dup_d = 1'b1;
      if (free_acc_c)  in_use_d[free_tag]  = 1'b0;
      if (alloc_acc_c) in_use_d[alloc_tag] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_use_q <= '0;
      dup_q    <= 1'b0;
    end else begin
      in_use_q <= in_use_d;
      dup_q    <= dup_d;
    end
  end

  assign dup_err = dup_q;
`else
  assign free_ok_c = 1'b1;
  assign dup_err   = 1'b0;
`endif

  assign free_acc_c = free_valid && !full_c && free_ok_c && !flush;

  // Next-state for pointers, storage, count and overflow flag.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = TAG_W'(i);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = CW'(DEPTH);
    end else begin
      if (free_valid && full_c) ovf_d = 1'b1;
      if (alloc_acc_c) rd_ptr_d = rd_ptr_q + TAG_W'(1);
      if (free_acc_c) begin
        mem_d[wr_ptr_q] = free_tag;
        wr_ptr_d        = wr_ptr_q + TAG_W'(1);
      end
      count_d = count_q + CW'(free_acc_c) - CW'(alloc_acc_c);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= CW'(DEPTH);
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign alloc_tag    = mem_q[rd_ptr_q];
  assign alloc_valid  = !empty_c;
  assign count        = count_q;
  assign empty        = empty_c;
  assign full         = full_c;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_tag_fifo.sv
// Directed bench for tag_fifo: reset, drain, wrap, simultaneous events, flush and reset priority.
module tb_tag_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       alloc_req = 1'b0;
  logic [4:0] alloc_tag;
  logic       alloc_valid;
  logic       free_valid = 1'b0;
  logic [4:0] free_tag = '0;
  logic [5:0] count;
  logic       empty;
  logic       full;
  logic       overflow_err;
  logic       dup_err;

  int checks   = 0;
  int failures = 0;

  tag_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_tag    (alloc_tag),
    .alloc_valid  (alloc_valid),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow_err (overflow_err),
    .dup_err      (dup_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are stable 1ns after the edge.
  task automatic cyc(input logic a, input logic fv, input logic [4:0] ft,
                     input logic fl, input logic rs);
    alloc_req  = a;
    free_valid = fv;
    free_tag   = ft;
    flush      = fl;
    reset      = rs;
    @(posedge clock);
    #1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = '0;
    flush      = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 1);
    chk("rst_tag", int'(alloc_tag), 0);
    chk("rst_valid", int'(alloc_valid), 1);
    chk("rst_full", int'(full), 1);
    chk("rst_empty", int'(empty), 0);
    chk("rst_count", int'(count), 32);
    chk("rst_ovf", int'(overflow_err), 0);
    chk("rst_dup", int'(dup_err), 0);

    // Drain all 32 tags in order
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag", int'(alloc_tag), i);
      cyc(1, 0, 0, 0, 0);
      chk("drain_count", int'(count), 31 - i);
    end
    chk("drain_valid", int'(alloc_valid), 0);
    chk("drain_empty", int'(empty), 1);
    cyc(1, 0, 0, 0, 0);
    chk("alloc_empty_count", int'(count), 0);
    chk("alloc_empty_valid", int'(alloc_valid), 0);

    // Refill out of order and drain in FIFO order
    cyc(0, 1, 5'd7, 0, 0);
    cyc(0, 1, 5'd3, 0, 0);
    cyc(0, 1, 5'd20, 0, 0);
    chk("refill_count", int'(count), 3);
    chk("wrap_tag0", int'(alloc_tag), 7);
    cyc(1, 0, 0, 0, 0);
    chk("wrap_tag1", int'(alloc_tag), 3);
    cyc(1, 0, 0, 0, 0);
    chk("wrap_tag2", int'(alloc_tag), 20);
    cyc(1, 0, 0, 0, 0);
    chk("wrap_count", int'(count), 0);

    // 40 free/alloc pairs push both pointers past the wrap
    for (int k = 0; k < 40; k++) begin
      cyc(0, 1, 5'(k % 32), 0, 0);
      chk("pair_tag", int'(alloc_tag), k % 32);
      cyc(1, 0, 0, 0, 0);
    end
    chk("pair_count", int'(count), 0);

    // Simultaneous alloc + free while full
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 5'd5, 0, 0);
    chk("full_sim_count", int'(count), 31);
    chk("full_sim_ovf", int'(overflow_err), 1);
    chk("full_sim_tag", int'(alloc_tag), 1);

    // Simultaneous alloc + free while empty; no same-cycle bypass
    for (int i = 0; i < 31; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_empty_valid", int'(alloc_valid), 0);
    cyc(1, 1, 5'd9, 0, 0);
    chk("empty_sim_count", int'(count), 1);
    chk("empty_sim_valid", int'(alloc_valid), 1);
    chk("empty_sim_tag", int'(alloc_tag), 9);

    // Flush mid-operation; sticky overflow must survive
    cyc(0, 0, 0, 1, 0);
    chk("flush1_count", int'(count), 32);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 5'd4, 0, 0);
    cyc(0, 1, 5'd8, 0, 0);
    chk("pre_flush_count", int'(count), 24);
    cyc(1, 1, 5'd6, 1, 0);
    chk("flush_count", int'(count), 32);
    chk("flush_tag", int'(alloc_tag), 0);
    chk("flush_ovf", int'(overflow_err), 1);
    chk("flush_full", int'(full), 1);

    // Reset beats flush, alloc and free
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_rst_count", int'(count), 22);
    cyc(1, 1, 5'd3, 1, 1);
    chk("rstpri_count", int'(count), 32);
    chk("rstpri_tag", int'(alloc_tag), 0);
    chk("rstpri_ovf", int'(overflow_err), 0);
    chk("rstpri_dup", int'(dup_err), 0);

    // Duplicate free of tag 1
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 5'd1, 0, 0);
    chk("dup_first_count", int'(count), 31);
    cyc(0, 1, 5'd1, 0, 0);
`ifdef TAG_FIFO_DUPCHK_EN
    chk("dup_count", int'(count), 31);
    chk("dup_err", int'(dup_err), 1);
`else
    chk("dup_count", int'(count), 32);
    chk("dup_err", int'(dup_err), 0);
`endif
    chk("dup_ovf", int'(overflow_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_fifo.md
Name: tag_fifo

Overview:
Free-list allocator for the 5-bit rename/ROB tags, sitting directly upstream of the ROB.
- At dispatch it supplies the next free tag; this value becomes Dispatch_Rd_tag and qualifies new_rd_tag/new_rd_tag_valid.
- At retire it reclaims the tag from Retire_rd_tag when Retire_valid is asserted.
- On flush (ROB flush_flag) all in-flight tags are discarded and the full list is restored.

Parameters:
TAG_W, 5, tag width in bits.
DEPTH, 32, number of tags; must equal 2**TAG_W.

Ports:
clock  in  1  single clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
flush  in  1  from ROB flush_flag; restores the full free list.
alloc_req  in  1  dispatch consumes alloc_tag this cycle.
alloc_tag  out  TAG_W  next free tag (show-ahead, combinational from storage).
alloc_valid  out  1  alloc_tag is valid (count != 0).
free_valid  in  1  driven by Retire_valid; return free_tag to the list.
free_tag  in  TAG_W  driven by Retire_rd_tag.
count  out  TAG_W+1  number of free tags, 0..DEPTH.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
overflow_err  out  1  sticky; set when a free is attempted while full.
dup_err  out  1  sticky; duplicate-free detect (optional feature), else 0.

Behaviour:
- Storage: DEPTH x TAG_W circular buffer, rd_ptr, wr_ptr (TAG_W bits, natural wrap DEPTH-1 -> 0), count register.
- Reset (reset=1 at posedge):
  - mem[i] = i for all i; rd_ptr = 0; wr_ptr = 0; count = DEPTH.
  - overflow_err = 0; dup_err = 0.
  - Resulting outputs: alloc_tag = 0, alloc_valid = 1, full = 1, empty = 0.
- Priority: reset > flush > alloc/free.
- Flush cycle: identical reinit to reset, except sticky error flags are held. alloc_req and free_valid in the same cycle are ignored. Takes effect the next cycle.
- Outputs: alloc_tag = mem[rd_ptr]; alloc_valid = !empty. No tag is ever presented when empty; zero-cycle bypass from free to alloc is not allowed.
- Alloc: accepted iff alloc_req && alloc_valid. Then rd_ptr++, and the next tag is visible the following cycle. alloc_req while empty is ignored with no state change.
- Free: accepted iff free_valid && !full (evaluated with pre-cycle count). Then mem[wr_ptr] = free_tag and wr_ptr++. free_valid while full is ignored and sets overflow_err.
- Simultaneous accepted alloc + free: both pointers advance and count is unchanged.
  - When full (count=32): alloc accepted, free rejected (overflow), count becomes 31.
  - When empty: free accepted, alloc rejected, count becomes 1.
- Count update: count_next = count + free_acc - alloc_acc, computed at TAG_W+1 bits; it never wraps.
- Latency: alloc and free both take 1 cycle; a freed tag is allocatable no earlier than the cycle after the free.

Optional Feature:
TAG_FIFO_DUPCHK_EN
- Enabled:
  - Adds a DEPTH-bit in_use bitmap, cleared on reset and flush.
  - Accepted alloc sets bit[alloc_tag]; accepted free clears bit[free_tag].
  - A free of a tag whose bit is 0 is rejected (no pointer or count change) and sets dup_err.
  - Alloc and free of the same tag in one cycle is legal only if the bit was already set.
- Disabled: no bitmap; dup_err is tied to 0; all frees are accepted per the Behaviour rules.

Decomposition:
- Shared package rob_pkg: TAG_W, ROB_DEPTH, tag_t typedef, inst_type encodings (2'b00 rd-valid, 2'b01 branch, 2'b10 store).
- No sub-module. The buffer is a plain register array inside tag_fifo; reinit on flush requires parallel write of all entries, so a RAM macro is not allowed.

Test Plan:
- Reset then 32 back-to-back alloc_req:
  - alloc_tag sequence 0,1,...,31; count 32 -> 0.
  - After the 32nd alloc, alloc_valid=0 and empty=1.
  - A 33rd alloc_req causes no change.
- Wrap-around: from empty, free tags 7, 3, 20, then alloc x3 -> tags 7, 3, 20 in order, count returns to 0. Repeat 40 alloc/free pairs to exercise pointer wrap.
- Simultaneous events:
  - At count=32, alloc_req + free_valid(tag 5) -> alloc tag 0, count=31, overflow_err=1.
  - At count=0, alloc_req + free_valid(tag 9) -> count=1, alloc_valid=1, alloc_tag=9 next cycle.
- Flush mid-operation: allocate 10 tags, free 2, then assert flush together with alloc_req -> next cycle count=32, alloc_tag=0, alloc request dropped, overflow_err unchanged.
- Reset priority: after 10 allocs, assert reset and flush together with alloc_req and free_valid -> full reinit, all error flags 0.
- With TAG_FIFO_DUPCHK_EN:
  - Alloc tags 0,1; free 1, then free 1 again -> second free rejected, dup_err=1, count stays 31.
  - Without the macro the same stimulus gives count=32 and dup_err=0.
